// File: rtl/median_pkg.sv
// Shared defaults, index-width helper and sample type for the median filter.
package median_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int N_DEF     = 9;

   // Width of a counter that spans 0..n-1 (never narrower than one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W = idx_width(N_DEF);

   typedef logic [WIDTH_DEF-1:0] sample_t;

endpackage

// File: rtl/median_if.sv
// Sample-in / result-out bus of the median filter.
interface median_if
   import median_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);

   logic             DSI;
   logic [WIDTH-1:0] DI;
   logic [WIDTH-1:0] DO;
   logic             DSO;

   modport master (output DSI, DI, input  DO, DSO);
   modport slave  (input  DSI, DI, output DO, DSO);

endinterface

// File: rtl/median_cell.sv
// One slot of the descending sorted store: next value of s[i] when di_i is inserted.
module median_cell
   import median_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] di_i,    // sample being inserted
   input  logic [WIDTH-1:0] prev_i,  // s[i-1]; all ones for the top slot
   input  logic [WIDTH-1:0] cur_i,   // s[i]
   output logic [WIDTH-1:0] nxt_o    // s'[i]
);

   // Larger values keep their slot, the first slot not above di_i takes di_i,
   // everything below shifts down one place.
   always_comb begin
      if (cur_i > di_i) begin
         nxt_o = cur_i;
      end else if (prev_i > di_i) begin
         nxt_o = di_i;
      end else begin
         nxt_o = prev_i;
      end
   end

endmodule

// File: rtl/median.sv
// Block median filter: sorts N consecutive samples on the fly and emits the middle one.
module median
   import median_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int N     = N_DEF      // odd, >= 3
) (
   input  logic     CLK,
   input  logic     nRST,           // synchronous, active-high
   median_if.slave  bus
);

   localparam int CW  = idx_width(N);
   localparam int MID = (N - 1) / 2;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             dso_q, dso_d;
   logic [WIDTH-1:0] do_q, do_d;
   logic [WIDTH-1:0] s_q    [N];
   logic [WIDTH-1:0] s_d    [N];
   logic [WIDTH-1:0] s_prev [N];
   logic [WIDTH-1:0] s_ins  [N];

   // Upper-neighbour view of the store; the top slot sees an unbeatable value.
   always_comb begin
      s_prev[0] = '1;
      for (int unsigned i = 1; i < N; i++) begin
         s_prev[i] = s_q[i-1];
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_cell
      median_cell #(
         .WIDTH (WIDTH)
      ) u_cell (
         .di_i   (bus.DI),
         .prev_i (s_prev[g]),
         .cur_i  (s_q[g]),
         .nxt_o  (s_ins[g])
      );
   end

   // Capture/insert, block position tracking and abort on a gap in DSI.
   always_comb begin
      cnt_d  = cnt_q;
      done_d = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         s_d[i] = s_q[i];
      end
      if (bus.DSI) begin
         if (cnt_q == '0) begin
            s_d[0] = bus.DI;
            for (int unsigned i = 1; i < N; i++) begin
               s_d[i] = '0;
            end
         end else begin
            for (int unsigned i = 0; i < N; i++) begin
               s_d[i] = s_ins[i];
            end
         end
         if (cnt_q == CW'(N - 1)) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Result register: store is read one edge after the last capture, so a new
   // block may already be overwriting it on that same edge.
   always_comb begin
      dso_d = done_q;
      do_d  = done_q ? s_q[MID] : do_q;
   end

   // State registers with synchronous reset overriding any capture.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
         dso_q  <= 1'b0;
         do_q   <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            s_q[i] <= '0;
         end
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
         dso_q  <= dso_d;
         do_q   <= do_d;
         for (int unsigned i = 0; i < N; i++) begin
            s_q[i] <= s_d[i];
         end
      end
   end

   assign bus.DO  = do_q;
   assign bus.DSO = dso_q;

endmodule

// File: tb/tb_median.sv
// Self-checking bench for the block median filter (scoreboard of expected medians).
module tb_median;
   import median_pkg::*;

   localparam int W   = WIDTH_DEF;
   localparam int NS  = N_DEF;
   localparam int MID = (NS - 1) / 2;

   typedef sample_t blk_t [NS];

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   median_if #(.WIDTH(W)) bus ();

   median #(
      .WIDTH (W),
      .N     (NS)
   ) dut (
      .CLK  (clk),
      .nRST (rst),
      .bus  (bus)
   );

   int          n_vec   = 0;
   int          n_err   = 0;
   int unsigned cyc     = 0;
   int unsigned dso_cnt = 0;
   sample_t     sb      [$];
   int unsigned dso_cyc [$];
   sample_t     mon_exp;

   always @(posedge clk) cyc++;

   // Every DSO pulse pops one expected median.
   always @(negedge clk) begin
      if (bus.DSO === 1'b1) begin
         dso_cnt++;
         dso_cyc.push_back(cyc);
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_dso: DSO=1 with no block pending, DO=%0d", bus.DO);
         end else begin
            mon_exp = sb.pop_front();
            if (bus.DO !== mon_exp) begin
               n_err++;
               $display("FAIL median_value: DO=%0d expected %0d at cycle %0d", bus.DO, mon_exp, cyc);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d blocks pending", sb.size());
      $fatal(1, "watchdog");
   end

   // Reference median by rank counting: the element with at most MID smaller
   // elements and more than MID elements not larger.
   function automatic sample_t model_median(input blk_t b);
      int lt, le;
      for (int j = 0; j < NS; j++) begin
         lt = 0;
         le = 0;
         for (int k = 0; k < NS; k++) begin
            if (b[k] <  b[j]) lt++;
            if (b[k] <= b[j]) le++;
         end
         if (lt <= MID && le > MID) return b[j];
      end
      return '0;
   endfunction

   task automatic drive(input sample_t v);
      @(negedge clk);
      bus.DSI = 1'b1;
      bus.DI  = v;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.DSI = 1'b0;
         bus.DI  = sample_t'($urandom);
      end
   endtask

   task automatic send_block(input blk_t b, input sample_t exp);
      for (int i = 0; i < NS; i++) drive(b[i]);
      sb.push_back(exp);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      bus.DSI = 1'b1;
      bus.DI  = 8'd33;
      repeat (3) @(negedge clk);
      n_vec++;
      if (bus.DO !== 8'd0) begin
         n_err++;
         $display("FAIL reset_do: DO=%0d expected 0", bus.DO);
      end
      n_vec++;
      if (bus.DSO !== 1'b0) begin
         n_err++;
         $display("FAIL reset_dso: DSO=%b expected 0", bus.DSO);
      end
      rst     = 1'b0;
      bus.DSI = 1'b0;
   endtask

   task automatic test_basic();
      blk_t b = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
      send_block(b, 8'd5);
      @(negedge clk);
      bus.DSI = 1'b0;
      n_vec++;
      if (bus.DSO !== 1'b0) begin
         n_err++;
         $display("FAIL basic_early: DSO=%b expected 0 right after last capture", bus.DSO);
      end
      @(negedge clk);
      n_vec++;
      if (bus.DSO !== 1'b1 || bus.DO !== 8'd5) begin
         n_err++;
         $display("FAIL basic_result: DSO=%b DO=%0d expected DSO=1 DO=5", bus.DSO, bus.DO);
      end
      @(negedge clk);
      n_vec++;
      if (bus.DSO !== 1'b0 || bus.DO !== 8'd5) begin
         n_err++;
         $display("FAIL basic_hold: DSO=%b DO=%0d expected DSO=0 DO=5", bus.DSO, bus.DO);
      end
      drain();
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL basic_drain: %0d results missing, expected 0", sb.size());
      end
   endtask

   task automatic test_extremes();
      blk_t a = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd128};
      blk_t e = '{8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17};
      send_block(a, 8'd128);
      idle(2);
      send_block(e, 8'd17);
      idle(1);
      drain();
      n_vec++;
      if (sb.size() != 0 || bus.DO !== 8'd17) begin
         n_err++;
         $display("FAIL extremes: pending=%0d DO=%0d expected pending=0 DO=17", sb.size(), bus.DO);
      end
   endtask

   task automatic test_back_to_back();
      blk_t a = '{8'd40, 8'd5, 8'd80, 8'd40, 8'd3, 8'd90, 8'd41, 8'd39, 8'd0};
      blk_t b = '{8'd200, 8'd255, 8'd199, 8'd250, 8'd1, 8'd201, 8'd2, 8'd200, 8'd100};
      int unsigned start = dso_cnt;
      dso_cyc.delete();
      send_block(a, 8'd40);
      send_block(b, 8'd200);
      idle(1);
      drain();
      repeat (2) @(negedge clk);
      n_vec++;
      if (dso_cnt - start != 2) begin
         n_err++;
         $display("FAIL b2b_count: %0d pulses expected 2", dso_cnt - start);
      end
      n_vec++;
      if (dso_cyc.size() < 2 || dso_cyc[1] - dso_cyc[0] != 9) begin
         n_err++;
         $display("FAIL b2b_spacing: pulses=%0d spacing=%0d expected 9", dso_cyc.size(),
                  (dso_cyc.size() < 2) ? 0 : dso_cyc[1] - dso_cyc[0]);
      end
   endtask

   task automatic test_abort();
      blk_t b = '{8'd100, 8'd50, 8'd77, 8'd120, 8'd10, 8'd90, 8'd60, 8'd200, 8'd30};
      int unsigned start = dso_cnt;
      for (int i = 0; i < 5; i++) drive(sample_t'(250 + i));
      idle(1);
      send_block(b, 8'd77);
      idle(1);
      drain();
      repeat (3) @(negedge clk);
      n_vec++;
      if (dso_cnt - start != 1 || bus.DO !== 8'd77) begin
         n_err++;
         $display("FAIL abort: pulses=%0d DO=%0d expected pulses=1 DO=77", dso_cnt - start, bus.DO);
      end
   endtask

   task automatic test_reset_mid();
      blk_t b = '{8'd30, 8'd90, 8'd10, 8'd70, 8'd50, 8'd20, 8'd80, 8'd40, 8'd60};
      for (int i = 0; i < 6; i++) drive(sample_t'(i * 40 + 5));
      @(negedge clk);
      rst     = 1'b1;
      bus.DSI = 1'b1;
      bus.DI  = 8'd200;
      @(negedge clk);
      n_vec++;
      if (bus.DO !== 8'd0 || bus.DSO !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: DO=%0d DSO=%b expected DO=0 DSO=0", bus.DO, bus.DSO);
      end
      rst     = 1'b0;
      bus.DSI = 1'b0;
      send_block(b, 8'd50);
      idle(1);
      drain();
      n_vec++;
      if (sb.size() != 0 || bus.DO !== 8'd50) begin
         n_err++;
         $display("FAIL reset_mid_next: pending=%0d DO=%0d expected pending=0 DO=50", sb.size(), bus.DO);
      end
   endtask

   task automatic test_random();
      blk_t b;
      int   lo, hi;
      for (int k = 0; k < 1000; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(1, NS - 1)) drive(sample_t'($urandom));
            idle(1 + $urandom_range(0, 1));
         end
         lo = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 250) : 0;
         hi = ($urandom_range(0, 3) == 0) ? lo + $urandom_range(0, 5) : 255;
         if (hi > 255) hi = 255;
         for (int i = 0; i < NS; i++) b[i] = sample_t'($urandom_range(lo, hi));
         send_block(b, model_median(b));
         idle($urandom_range(0, 3));
      end
      idle(1);
      drain();
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL random_drain: %0d results missing, expected 0", sb.size());
      end
   endtask

   initial begin
      bus.DSI = 1'b0;
      bus.DI  = '0;
      test_reset();
      test_basic();
      test_extremes();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_random();
      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
